mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the fetch stage (read-only) and the memory stage (load/store).
- Sequences each access through a request/acknowledge handshake to the memory.
- Produces per-requester stall signals that the hazard unit ORs into the PC and pipeline-register stalls.
- Data port has priority over fetch, with a starvation guard so fetch always makes progress.

Parameters:
AW, 16, address width
DW, 16, data width
STARVE_MAX, 4, consecutive data-port wins while fetch is waiting before fetch is forced to win (1..15)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch wants the instruction at if_addr; held until if_valid
if_addr  in  AW  fetch address
if_kill  in  1  branch/jump redirect; discard any in-flight or pending fetch
hlt  in  1  halt; no new fetch is granted while high
if_rdata  out  DW  fetched instruction, valid when if_valid
if_valid  out  1  one-cycle pulse, fetch complete
if_stall  out  1  if_req & ~if_valid (combinational)
dm_re  in  1  load request; held until dm_valid
dm_we  in  1  store request; held until dm_valid
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_rdata  out  DW  load data, valid when dm_valid
dm_valid  out  1  one-cycle pulse, data access complete
dm_stall  out  1  (dm_re|dm_we) & ~dm_valid (combinational)
mem_req  out  1  memory transaction active
mem_we  out  1  write when high
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  read data, valid when mem_ack
mem_ack  in  1  one-cycle completion from memory

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_DM, RESP_IF, RESP_DM.
- Reset: state IDLE; starve counter 0; kill flag 0. mem_req, mem_we, if_valid and dm_valid are 0. mem_addr, mem_wdata, if_rdata and dm_rdata are 0.
- IDLE grant rules:
  - If dm_re or dm_we is high and the starve counter is below STARVE_MAX: grant DM, go to BUSY_DM. If if_req is also eligible, increment the starve counter.
  - Otherwise, if if_req & ~if_kill & ~hlt: grant IF, go to BUSY_IF, clear the starve counter.
  - If the starve counter equals STARVE_MAX and fetch is eligible, fetch wins even over a pending data request.
  - If fetch becomes ineligible, clear the starve counter.
- mem_req, mem_we, mem_addr and mem_wdata are registered and held stable for the whole BUSY state. mem_we = dm_we for DM grants, 0 for IF grants.
- dm_re and dm_we asserted together is illegal; the store wins.
- BUSY_x on mem_ack:
  - Drop mem_req the next cycle.
  - Capture mem_rdata into x_rdata and go to RESP_x.
  - Memory may ack in the first BUSY cycle.
  - No timeout; a missing ack hangs the state indefinitely.
- RESP_x: x_valid = 1 for exactly this cycle, then return to IDLE. Requesters advance on this edge, so IDLE always samples the next request.
- Minimum latency: request visible in cycle 0, mem_req from cycle 1, ack in cycle 1, valid in cycle 2, next grant decision in cycle 3.
- if_kill during BUSY_IF: set the kill flag. The transaction is not aborted. On ack, go to IDLE with no RESP_IF and no if_valid, then clear the flag.
- if_kill in RESP_IF: suppress if_valid.
- if_kill with if_req in IDLE: fetch is not granted that cycle.
- hlt only blocks new IF grants. An in-flight fetch completes normally; DM accesses continue.
- Reset mid-transaction: mem_req is low after the reset edge and any pending ack is ignored. The memory must tolerate an abandoned request.

Optional Feature:
MEM_ARB_PERF_EN
- Defined: adds outputs if_wait_cnt[15:0] and dm_wait_cnt[15:0]. Each is a saturating count of cycles where the respective stall is high. Both reset to 0 and stick at 16'hFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, BUSY_IF, BUSY_DM, RESP_IF, RESP_DM), grant-source enum (GNT_IF, GNT_DM), default widths, STARVE_MAX bound check constant.
- One sub-module mem_arb_starve_ctr: 4-bit counter with inc/clr/sat-flag, instantiated once.
- Everything else inline.

Test Plan:
- if_req=1, if_addr=16'h0010, mem_ack one cycle after mem_req, mem_rdata=16'hB123 -> mem_req high cycles 1-1; if_valid pulse cycle 2 with if_rdata=16'hB123; if_stall high cycles 0-1.
- dm_we=1, dm_addr=16'h0200, dm_wdata=16'h55AA and if_req=1 simultaneously -> DM granted first, mem_we=1, mem_addr=16'h0200, mem_wdata=16'h55AA; fetch granted in the following IDLE.
- Back-to-back loads held continuously with if_req=1, STARVE_MAX=4 -> 4 DM grants, then an IF grant, then DM resumes; starve counter returns to 0.
- if_kill pulsed in BUSY_IF, ack 3 cycles later -> no if_valid; next IDLE grants the new if_addr=16'h0040.
- hlt=1 with if_req=1 -> mem_req never asserted for fetch; a dm_re=1 access still completes with dm_valid.
- rst=1 while BUSY_DM with ack pending -> after the edge mem_req=0, dm_valid=0; a late mem_ack produces no valid pulse.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_AW         = 16;
    localparam int DEF_DW         = 16;
    localparam int STARVE_W       = 4;
    localparam int STARVE_MAX_LIM = 15;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        RESP_IF,
        RESP_DM
    } arb_state_t;

    typedef enum logic {
        GNT_IF,
        GNT_DM
    } gnt_src_t;

    // Clamp the starvation threshold into the range the 4-bit counter can represent.
    function automatic logic [STARVE_W-1:0] starve_bound(input int v);
        if (v < 1)
            return STARVE_W'(1);
        else if (v > STARVE_MAX_LIM)
            return STARVE_W'(STARVE_MAX_LIM);
        else
            return STARVE_W'(v);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/acknowledge bus between the arbiter (master) and the single-ported memory (slave).
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Counts consecutive data-port wins over a waiting fetch; sat tells the arbiter fetch must win.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter logic [STARVE_W-1:0] MAX = 4'd4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    output logic [STARVE_W-1:0] cnt,
    output logic                sat
);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != {STARVE_W{1'b1}})
            cnt <= cnt + STARVE_W'(1);
    end

    assign sat = (cnt >= MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store access to one single-ported unified memory.
// Optional MEM_ARB_PERF_EN adds saturating stall-cycle counters if_wait_cnt / dm_wait_cnt.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_kill,
    input  logic          hlt,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          if_stall,

    input  logic          dm_re,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          dm_stall,

    mem_port_arbiter_if.master mem
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]   if_wait_cnt,
    output logic [15:0]   dm_wait_cnt
`endif
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = starve_bound(STARVE_MAX);

    arb_state_t          state;
    gnt_src_t            gnt_sel;
    logic                grant;
    logic                kill_flag;
    logic                if_valid_q;
    logic                dm_pend;
    logic                if_elig;
    logic                starve_inc;
    logic                starve_clr;
    logic                starve_sat;
    logic [STARVE_W-1:0] starve_cnt;

    assign dm_pend = dm_re | dm_we;
    assign if_elig = if_req & ~if_kill & ~hlt;

    // Data wins unless the starve counter has reached its limit; then a waiting fetch goes first.
    always_comb begin
        grant   = 1'b0;
        gnt_sel = GNT_IF;
        if (state == IDLE) begin
            if (dm_pend && !starve_sat) begin
                grant   = 1'b1;
                gnt_sel = GNT_DM;
            end else if (if_elig) begin
                grant   = 1'b1;
                gnt_sel = GNT_IF;
            end
        end
    end

    assign starve_inc = grant && (gnt_sel == GNT_DM) && if_elig;
    assign starve_clr = (state == IDLE) && (!if_elig || (grant && gnt_sel == GNT_IF));

    mem_arb_starve_ctr #(
        .MAX (STARVE_LIM)
    ) u_starve_ctr (
        .clk (clk),
        .rst (rst),
        .inc (starve_inc),
        .clr (starve_clr),
        .cnt (starve_cnt),
        .sat (starve_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            kill_flag     <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            if_rdata      <= '0;
            dm_rdata      <= '0;
            if_valid_q    <= 1'b0;
            dm_valid      <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant && gnt_sel == GNT_DM) begin
                        state         <= BUSY_DM;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= dm_we;
                        mem.mem_addr  <= dm_addr;
                        mem.mem_wdata <= dm_wdata;
                    end else if (grant) begin
                        state         <= BUSY_IF;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= 1'b0;
                        mem.mem_addr  <= if_addr;
                    end
                end
                // A killed fetch still runs to its ack so the memory sees a complete transaction.
                BUSY_IF: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        kill_flag   <= 1'b0;
                        if (kill_flag || if_kill) begin
                            state <= IDLE;
                        end else begin
                            if_rdata   <= mem.mem_rdata;
                            if_valid_q <= 1'b1;
                            state      <= RESP_IF;
                        end
                    end else if (if_kill) begin
                        kill_flag <= 1'b1;
                    end
                end
                BUSY_DM: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        dm_rdata    <= mem.mem_rdata;
                        dm_valid    <= 1'b1;
                        state       <= RESP_DM;
                    end
                end
                RESP_IF: state <= IDLE;
                RESP_DM: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign if_valid = if_valid_q & ~if_kill;
    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_pend & ~dm_valid;

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            if_wait_cnt <= '0;
            dm_wait_cnt <= '0;
        end else begin
            if (if_stall && if_wait_cnt != 16'hFFFF)
                if_wait_cnt <= if_wait_cnt + 16'd1;
            if (dm_stall && dm_wait_cnt != 16'hFFFF)
                dm_wait_cnt <= dm_wait_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; memory side is driven cycle by cycle.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_kill;
    logic        hlt;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        dm_re;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_valid;
    logic        dm_stall;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] if_wait_cnt;
    logic [15:0] dm_wait_cnt;
`endif

    int checks;
    int errors;

    mem_port_arbiter_if #(.AW(16), .DW(16)) mem_bus ();

    mem_port_arbiter #(
        .AW         (16),
        .DW         (16),
        .STARVE_MAX (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_kill  (if_kill),
        .hlt      (hlt),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .if_stall (if_stall),
        .dm_re    (dm_re),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_valid (dm_valid),
        .dm_stall (dm_stall),
        .mem      (mem_bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .if_wait_cnt (if_wait_cnt),
        .dm_wait_cnt (dm_wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the rising edge; checks happen on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; if_kill = 1'b0; hlt = 1'b0;
        dm_re = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        next_cycle();
        next_cycle();
        sample();
        checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req got %0h want 0", mem_bus.mem_req); end
        checks++; if (mem_bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we got %0h want 0", mem_bus.mem_we); end
        checks++; if (mem_bus.mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mem_addr got %0h want 0", mem_bus.mem_addr); end
        checks++; if (mem_bus.mem_wdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mem_wdata got %0h want 0", mem_bus.mem_wdata); end
        checks++; if ({if_valid, dm_valid} !== 2'b00) begin errors++; $display("[TB] FAIL reset_valids got %b want 00", {if_valid, dm_valid}); end
        checks++; if ({if_rdata, dm_rdata} !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %0h want 0", {if_rdata, dm_rdata}); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        // cycle 0
        next_cycle();
        if_req = 1'b1; if_addr = 16'h0010;
        sample();
        checks++; if (if_stall !== 1'b1) begin errors++; $display("[TB] FAIL fetch_stall_c0 got %0h want 1", if_stall); end
        checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL fetch_req_c0 got %0h want 0", mem_bus.mem_req); end
        // cycle 1
        next_cycle();
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'hB123;
        sample();
        checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL fetch_req_c1 got %0h want 1", mem_bus.mem_req); end
        checks++; if (mem_bus.mem_addr !== 16'h0010) begin errors++; $display("[TB] FAIL fetch_addr_c1 got %0h want 0010", mem_bus.mem_addr); end
        checks++; if (mem_bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL fetch_we_c1 got %0h want 0", mem_bus.mem_we); end
        checks++; if (if_stall !== 1'b1) begin errors++; $display("[TB] FAIL fetch_stall_c1 got %0h want 1", if_stall); end
        // cycle 2
        next_cycle();
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 16'h0000;
        sample();
        checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL fetch_req_c2 got %0h want 0", mem_bus.mem_req); end
        checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL fetch_valid_c2 got %0h want 1", if_valid); end
        checks++; if (if_rdata !== 16'hB123) begin errors++; $display("[TB] FAIL fetch_rdata_c2 got %0h want b123", if_rdata); end
        checks++; if (if_stall !== 1'b0) begin errors++; $display("[TB] FAIL fetch_stall_c2 got %0h want 0", if_stall); end
        // cycle 3
        next_cycle();
        if_req = 1'b0;
        sample();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_valid_c3 got %0h want 0", if_valid); end
`ifdef MEM_ARB_PERF_EN
        checks++; if (if_wait_cnt !== 16'd2) begin errors++; $display("[TB] FAIL perf_if_wait got %0d want 2", if_wait_cnt); end
        checks++; if (dm_wait_cnt !== 16'd0) begin errors++; $display("[TB] FAIL perf_dm_wait got %0d want 0", dm_wait_cnt); end
`endif
    endtask

    task automatic test_dm_priority();
        // cycle 0: store and fetch arrive together
        next_cycle();
        dm_we = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h55AA;
        if_req = 1'b1; if_addr = 16'h0300;
        sample();
        checks++; if ({dm_stall, if_stall} !== 2'b11) begin errors++; $display("[TB] FAIL prio_stalls_c0 got %b want 11", {dm_stall, if_stall}); end
        // cycle 1
        next_cycle();
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h0000;
        sample();
        checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL prio_req_c1 got %0h want 1", mem_bus.mem_req); end
        checks++; if (mem_bus.mem_we !== 1'b1) begin errors++; $display("[TB] FAIL prio_we_c1 got %0h want 1", mem_bus.mem_we); end
        checks++; if (mem_bus.mem_addr !== 16'h0200) begin errors++; $display("[TB] FAIL prio_addr_c1 got %0h want 0200", mem_bus.mem_addr); end
        checks++; if (mem_bus.mem_wdata !== 16'h55AA) begin errors++; $display("[TB] FAIL prio_wdata_c1 got %0h want 55aa", mem_bus.mem_wdata); end
        // cycle 2
        next_cycle();
        mem_bus.mem_ack = 1'b0;
        sample();
        checks++; if (dm_valid !== 1'b1) begin errors++; $display("[TB] FAIL prio_dm_valid_c2 got %0h want 1", dm_valid); end
        checks++; if (dm_stall !== 1'b0) begin errors++; $display("[TB] FAIL prio_dm_stall_c2 got %0h want 0", dm_stall); end
        // cycle 3: store retired, fetch granted in this IDLE
        next_cycle();
        dm_we = 1'b0;
        sample();
        checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL prio_req_c3 got %0h want 0", mem_bus.mem_req); end
        // cycle 4
        next_cycle();
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h1234;
        sample();
        checks++; if ({mem_bus.mem_req, mem_bus.mem_we} !== 2'b10) begin errors++; $display("[TB] FAIL prio_if_req_we_c4 got %b want 10", {mem_bus.mem_req, mem_bus.mem_we}); end
        checks++; if (mem_bus.mem_addr !== 16'h0300) begin errors++; $display("[TB] FAIL prio_if_addr_c4 got %0h want 0300", mem_bus.mem_addr); end
        // cycle 5
        next_cycle();
        mem_bus.mem_ack = 1'b0;
        sample();
        checks++; if (if_valid !== 1'b1 || if_rdata !== 16'h1234) begin errors++; $display("[TB] FAIL prio_if_resp_c5 got valid %0h data %0h want 1 1234", if_valid, if_rdata); end
        next_cycle();
        if_req = 1'b0;
    endtask

    // Loads held continuously against a waiting fetch: DM x4, IF, then DM again.
    task automatic test_starvation();
        logic        exp_dm;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
        for (int k = 0; k < 6; k++) begin
            exp_dm   = (k != 4);
            exp_addr = exp_dm ? 16'h0400 : 16'h0500;
            exp_data = 16'(16'hD000 + k);
            next_cycle();
            dm_re = 1'b1; dm_addr = 16'h0400;
            if_req = 1'b1; if_addr = 16'h0500;
            mem_bus.mem_ack = 1'b0;
            next_cycle();
            mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = exp_data;
            sample();
            checks++; if (mem_bus.mem_addr !== exp_addr) begin errors++; $display("[TB] FAIL starve_addr_%0d got %0h want %0h", k, mem_bus.mem_addr, exp_addr); end
            next_cycle();
            mem_bus.mem_ack = 1'b0;
            sample();
            if (exp_dm) begin
                checks++; if ({dm_valid, if_valid} !== 2'b10 || dm_rdata !== exp_data) begin errors++; $display("[TB] FAIL starve_dm_resp_%0d got valid %b data %0h want 10 %0h", k, {dm_valid, if_valid}, dm_rdata, exp_data); end
            end else begin
                checks++; if ({dm_valid, if_valid} !== 2'b01 || if_rdata !== exp_data) begin errors++; $display("[TB] FAIL starve_if_resp_%0d got valid %b data %0h want 01 %0h", k, {dm_valid, if_valid}, if_rdata, exp_data); end
            end
        end
        next_cycle();
        dm_re = 1'b0; if_req = 1'b0;
        sample();
        checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL starve_idle_req got %0h want 0", mem_bus.mem_req); end
    endtask

    task automatic test_kill();
        next_cycle();
        if_req = 1'b1; if_addr = 16'h0020;
        // cycle 1: BUSY_IF, redirect arrives
        next_cycle();
        if_kill = 1'b1;
        sample();
        checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL kill_req_c1 got %0h want 1", mem_bus.mem_req); end
        next_cycle();
        if_kill = 1'b0; if_addr = 16'h0040;
        next_cycle();
        sample();
        checks++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h0020) begin errors++; $display("[TB] FAIL kill_hold_c3 got req %0h addr %0h want 1 0020", mem_bus.mem_req, mem_bus.mem_addr); end
        // cycle 4: late ack of the discarded fetch
        next_cycle();
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'hDEAD;
        next_cycle();
        mem_bus.mem_ack = 1'b0;
        sample();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL kill_no_valid_c5 got %0h want 0", if_valid); end
        checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL kill_req_c5 got %0h want 0", mem_bus.mem_req); end
        next_cycle();
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h4040;
        sample();
        checks++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h0040) begin errors++; $display("[TB] FAIL kill_regrant_c6 got req %0h addr %0h want 1 0040", mem_bus.mem_req, mem_bus.mem_addr); end
        next_cycle();
        mem_bus.mem_ack = 1'b0;
        sample();
        checks++; if (if_valid !== 1'b1 || if_rdata !== 16'h4040) begin errors++; $display("[TB] FAIL kill_resp_c7 got valid %0h data %0h want 1 4040", if_valid, if_rdata); end
        next_cycle();
        if_req = 1'b0;
    endtask

    task automatic test_halt();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            hlt = 1'b1; if_req = 1'b1; if_addr = 16'h0060;
            sample();
            checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_no_req_%0d got %0h want 0", i, mem_bus.mem_req); end
        end
        next_cycle();
        dm_re = 1'b1; dm_addr = 16'h0700;
        next_cycle();
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h7777;
        sample();
        checks++; if ({mem_bus.mem_req, mem_bus.mem_we} !== 2'b10 || mem_bus.mem_addr !== 16'h0700) begin errors++; $display("[TB] FAIL halt_dm_req got req/we %b addr %0h want 10 0700", {mem_bus.mem_req, mem_bus.mem_we}, mem_bus.mem_addr); end
        next_cycle();
        mem_bus.mem_ack = 1'b0;
        sample();
        checks++; if (dm_valid !== 1'b1 || dm_rdata !== 16'h7777) begin errors++; $display("[TB] FAIL halt_dm_resp got valid %0h data %0h want 1 7777", dm_valid, dm_rdata); end
        next_cycle();
        dm_re = 1'b0;
        next_cycle();
        sample();
        checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_after_dm got %0h want 0", mem_bus.mem_req); end
        hlt = 1'b0; if_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        next_cycle();
        dm_re = 1'b1; dm_addr = 16'h0800;
        next_cycle();
        rst = 1'b1;
        sample();
        checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy got %0h want 1", mem_bus.mem_req); end
        next_cycle();
        rst = 1'b0; dm_re = 1'b0;
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h9999;
        sample();
        checks++; if ({mem_bus.mem_req, dm_valid} !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_after_edge got req/valid %b want 00", {mem_bus.mem_req, dm_valid}); end
        next_cycle();
        mem_bus.mem_ack = 1'b0;
        sample();
        checks++; if ({mem_bus.mem_req, dm_valid, if_valid} !== 3'b000) begin errors++; $display("[TB] FAIL rstmid_late_ack got req/dv/iv %b want 000", {mem_bus.mem_req, dm_valid, if_valid}); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fetch();
        test_dm_priority();
        test_starvation();
        test_kill();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
